smart_cargo_escalonador: RTL and testbench
==========================================

SMART_CARGO_ESCALONADOR -- requirements
Module: smart_cargo_escalonador

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 SHALL have port: clock  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high, clears all state.
REQ-004 SHALL have port: novo_pedido  in  1  one-cycle pulse; origem/destino valid this cycle.
REQ-005 SHALL have port: origem  in  2  pickup floor 0..3.
REQ-006 SHALL have port: destino  in  2  drop floor 0..3.
REQ-007 SHALL have port: andar_atual  in  2  current floor from datapath.
REQ-008 SHALL have port: parada_concluida  in  1  one-cycle pulse; car stopped and serviced at andar_atual.
REQ-009 SHALL have port: prox_parada  out  2  registered target floor.
REQ-010 SHALL have port: tem_destino  out  1  at least one stop pending.
REQ-011 SHALL have port: sobe  out  1  1 = target above andar_atual; 0 = below, equal or idle.
REQ-012 SHALL have port: coloca_objetos  out  1  one-cycle pulse; at least one pickup serviced.
REQ-013 SHALL have port: tira_objetos  out  1  one-cycle pulse; at least one drop serviced.
REQ-014 SHALL have port: recusado  out  1  one-cycle pulse; request rejected.
REQ-015 SHALL have port: ocupacao  out  3  valid entries, 0..4.

Function
REQ-016 SHALL hold a 4-entry table; each entry has valid, embarcado, origem[1:0], destino[1:0].
REQ-017 Accept novo_pedido into the lowest-index free entry (valid=1, embarcado=0); if table full or origem==destino, drop it and pulse recusado next cycle.
REQ-018 Stop set S = origem of valid non-embarcado entries, plus destino of valid embarcado entries.
REQ-019 On parada_concluida at floor F: every valid non-embarcado entry with origem==F sets embarcado=1; every valid embarcado entry with destino==F clears valid; pulse coloca_objetos and/or tira_objetos next cycle accordingly.
REQ-020 An entry embarked by a parada_concluida SHALL NOT be dropped by that same pulse.
REQ-021 novo_pedido coincident with parada_concluida: both are applied; the new entry is not serviced by that pulse, even if origem==F.
REQ-022 Direction FSM states: OCIOSO, SUBINDO, DESCENDO; reset state OCIOSO.
REQ-023 If andar_atual is in S: prox_parada=andar_atual, sobe=0, state unchanged.
REQ-024 SUBINDO: target = lowest floor in S above andar_atual; if none, go DESCENDO and target = highest floor in S below.
REQ-025 DESCENDO: mirror of REQ-024.
REQ-026 OCIOSO with S non-empty: nearest floor in S; tie resolved upward; enter SUBINDO/DESCENDO accordingly.
REQ-027 S empty: state OCIOSO, tem_destino=0, sobe=0, prox_parada holds its last value.
REQ-028 Outputs SHALL be registered from the table state: a table change at edge N appears on prox_parada/tem_destino/sobe after edge N+1.
REQ-029 ocupacao SHALL equal the number of valid entries, updated the same edge as the table.

Reset
REQ-030 Reset SHALL clear all entries; set prox_parada=0, tem_destino=0, sobe=0, coloca_objetos=0, tira_objetos=0, recusado=0, ocupacao=0, state OCIOSO.
REQ-031 Reset mid-operation SHALL discard all pending requests; no pulse outputs on release.

Configuration
REQ-032 Macro SMART_CARGO_CARONA_EN defined: REQ-018 through REQ-026 apply (ride-along, all entries serviced by sweep).
REQ-033 Macro SMART_CARGO_CARONA_EN undefined: S contains only the oldest valid entry (FIFO by acceptance order); parada_concluida services only that entry; other entries wait.

Verification
REQ-034 Reset; andar_atual=0; novo_pedido 2->3 -> after 2 cycles tem_destino=1, prox_parada=2, sobe=1, ocupacao=1.
REQ-035 At floor 2, parada_concluida -> coloca_objetos pulse, prox_parada=3; at floor 3, parada_concluida -> tira_objetos pulse, tem_destino=0, ocupacao=0.
REQ-036 Five requests 0->1 back-to-back -> fifth pulses recusado, ocupacao=4; request 2->2 -> recusado.
REQ-037 CARONA_EN, SUBINDO at floor 1 with pending 3->0, new 2->3 -> prox_parada=2 before 3, then reverse to 0; without macro -> prox_parada=3 first.
REQ-038 novo_pedido 1->2 in same cycle as parada_concluida at floor 1 -> no coloca_objetos pulse; next target remains floor 1.
REQ-039 Reset asserted with 3 entries pending -> ocupacao=0, tem_destino=0 immediately and no pulses after release.

Source files
------------

// File: rtl/smart_cargo_escalonador.sv
// Cargo car scheduler: 4-entry pickup/drop table driving a sweep direction FSM.
// Define SMART_CARGO_CARONA_EN for ride-along service; default serves oldest only.
module smart_cargo_escalonador (
  input  logic       clock,
  input  logic       reset,
  input  logic       novo_pedido,
  input  logic [1:0] origem,
  input  logic [1:0] destino,
  input  logic [1:0] andar_atual,
  input  logic       parada_concluida,
  output logic [1:0] prox_parada,
  output logic       tem_destino,
  output logic       sobe,
  output logic       coloca_objetos,
  output logic       tira_objetos,
  output logic       recusado,
  output logic [2:0] ocupacao
);

  typedef enum logic [1:0] {OCIOSO, SUBINDO, DESCENDO} dir_e;

  dir_e            st_q;
  logic [3:0]      vld_q, vld_d;
  logic [3:0]      emb_q, emb_d;
  logic [3:0][1:0] org_q, org_d;
  logic [3:0][1:0] dst_q, dst_d;
  logic [2:0]      ocup_q, ocup_d;
  logic [1:0]      prox_q;
  logic            tem_q, sobe_q;
  logic            col_q, col_d;
  logic            tira_q, tira_d;
  logic            rec_q, rec_d;
  logic            acc;
  logic [1:0]      free;
  logic [3:0]      svc, stops;
  logic            has_up, has_dn, go_up;
  logic [1:0]      up_f, dn_f, du, dd;

`ifndef SMART_CARGO_CARONA_EN
  logic [3:0][1:0] ord_q, ord_d;
  logic [2:0]      n;
`endif

  // Entries eligible for service, and the floors they want visited
  always_comb begin
    svc   = '0;
    stops = '0;
`ifdef SMART_CARGO_CARONA_EN
    svc = vld_q;
`else
    svc[ord_q[0]] = vld_q[ord_q[0]];
`endif
    for (int i = 0; i < 4; i++)
      if (svc[i])
        stops[emb_q[i] ? dst_q[i] : org_q[i]] = 1'b1;
  end

  always_comb begin
    vld_d  = vld_q;
    emb_d  = emb_q;
    org_d  = org_q;
    dst_d  = dst_q;
    col_d  = 1'b0;
    tira_d = 1'b0;
    free   = '0;
    if (parada_concluida) begin
      for (int i = 0; i < 4; i++) begin
        if (svc[i] && !emb_q[i] && org_q[i] == andar_atual) begin
          emb_d[i] = 1'b1;
          col_d    = 1'b1;
        end else if (svc[i] && emb_q[i] && dst_q[i] == andar_atual) begin
          vld_d[i] = 1'b0;
          tira_d   = 1'b1;
        end
      end
    end
    for (int i = 3; i >= 0; i--)
      if (!vld_q[i]) free = 2'(i);
    rec_d = novo_pedido && ((&vld_q) || origem == destino);
    acc   = novo_pedido && !rec_d;
    if (acc) begin
      vld_d[free] = 1'b1;
      emb_d[free] = 1'b0;
      org_d[free] = origem;
      dst_d[free] = destino;
    end
    ocup_d = '0;
    for (int i = 0; i < 4; i++)
      ocup_d = ocup_d + {2'b00, vld_d[i]};
  end

`ifndef SMART_CARGO_CARONA_EN
  // Acceptance order; only the head is ever serviced, so only it retires
  always_comb begin
    ord_d = ord_q;
    n     = ocup_q;
    if (tira_d) begin
      ord_d[0] = ord_q[1];
      ord_d[1] = ord_q[2];
      ord_d[2] = ord_q[3];
      n        = n - 3'd1;
    end
    if (acc) ord_d[n[1:0]] = free;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ord_q <= '0;
    else       ord_q <= ord_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      emb_q  <= '0;
      org_q  <= '0;
      dst_q  <= '0;
      ocup_q <= '0;
      col_q  <= 1'b0;
      tira_q <= 1'b0;
      rec_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      emb_q  <= emb_d;
      org_q  <= org_d;
      dst_q  <= dst_d;
      ocup_q <= ocup_d;
      col_q  <= col_d;
      tira_q <= tira_d;
      rec_q  <= rec_d;
    end
  end

  always_comb begin
    has_up = 1'b0;
    has_dn = 1'b0;
    up_f   = andar_atual;
    dn_f   = andar_atual;
    go_up  = 1'b0;
    for (int f = 3; f >= 0; f--)
      if (stops[f] && 2'(f) > andar_atual) begin
        has_up = 1'b1;
        up_f   = 2'(f);
      end
    for (int f = 0; f < 4; f++)
      if (stops[f] && 2'(f) < andar_atual) begin
        has_dn = 1'b1;
        dn_f   = 2'(f);
      end
    du = up_f - andar_atual;
    dd = andar_atual - dn_f;
    unique case (st_q)
      SUBINDO:  go_up = has_up;
      DESCENDO: go_up = !has_dn;
      default:  go_up = has_up && (!has_dn || du <= dd);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q   <= OCIOSO;
      prox_q <= '0;
      tem_q  <= 1'b0;
      sobe_q <= 1'b0;
    end else if (stops == '0) begin
      st_q   <= OCIOSO;
      tem_q  <= 1'b0;
      sobe_q <= 1'b0;
    end else begin
      tem_q <= 1'b1;
      if (stops[andar_atual]) begin
        prox_q <= andar_atual;
        sobe_q <= 1'b0;
      end else if (go_up) begin
        prox_q <= up_f;
        sobe_q <= 1'b1;
        st_q   <= SUBINDO;
      end else begin
        prox_q <= dn_f;
        sobe_q <= 1'b0;
        st_q   <= DESCENDO;
      end
    end
  end

  assign prox_parada    = prox_q;
  assign tem_destino    = tem_q;
  assign sobe           = sobe_q;
  assign coloca_objetos = col_q;
  assign tira_objetos   = tira_q;
  assign recusado       = rec_q;
  assign ocupacao       = ocup_q;

endmodule

// File: tb/tb_smart_cargo_escalonador.sv
// Bench for smart_cargo_escalonador: request-queue reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_smart_cargo_escalonador;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       novo_pedido = 1'b0;
  logic [1:0] origem = '0;
  logic [1:0] destino = '0;
  logic [1:0] andar_atual = '0;
  logic       parada_concluida = 1'b0;
  logic [1:0] prox_parada;
  logic       tem_destino, sobe;
  logic       coloca_objetos, tira_objetos, recusado;
  logic [2:0] ocupacao;

  smart_cargo_escalonador dut (
    .clock            (clock),
    .reset            (reset),
    .novo_pedido      (novo_pedido),
    .origem           (origem),
    .destino          (destino),
    .andar_atual      (andar_atual),
    .parada_concluida (parada_concluida),
    .prox_parada      (prox_parada),
    .tem_destino      (tem_destino),
    .sobe             (sobe),
    .coloca_objetos   (coloca_objetos),
    .tira_objetos     (tira_objetos),
    .recusado         (recusado),
    .ocupacao         (ocupacao)
  );

  always #5 clock = ~clock;

  typedef struct {
    int o;
    int d;
    bit e;
  } req_t;

  req_t mq[$];
  int   mdir;
  int   mprox, mtem, msobe, mcol, mtira, mrec, mocup;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef SMART_CARGO_CARONA_EN
  localparam bit CARONA = 1'b1;
`else
  localparam bit CARONA = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int served();
    if (CARONA) return mq.size();
    return (mq.size() > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    mdir = 0;
    mprox = 0; mtem = 0; msobe = 0;
    mcol = 0; mtira = 0; mrec = 0; mocup = 0;
  endtask

  // One clock edge of the reference, from the current inputs
  task automatic model_step();
    bit [3:0] s;
    int a, up, dn, oldsz, lim;
    bit goup;
    a = int'(andar_atual);
    s = '0;
    lim = served();
    for (int i = 0; i < lim; i++)
      s[mq[i].e ? mq[i].d : mq[i].o] = 1'b1;
    if (s == 0) begin
      mdir = 0; mtem = 0; msobe = 0;
    end else begin
      mtem = 1;
      if (s[a]) begin
        mprox = a; msobe = 0;
      end else begin
        up = -1; dn = -1;
        for (int f = 0; f < 4; f++) begin
          if (s[f] && f > a && up < 0) up = f;
          if (s[f] && f < a) dn = f;
        end
        if (mdir == 1)      goup = (up >= 0);
        else if (mdir == 2) goup = (dn < 0);
        else goup = (up >= 0) && (dn < 0 || (up - a) <= (a - dn));
        if (goup) begin
          mprox = up; msobe = 1; mdir = 1;
        end else begin
          mprox = dn; msobe = 0; mdir = 2;
        end
      end
    end
    oldsz = mq.size();
    mcol = 0; mtira = 0;
    if (parada_concluida) begin
      for (int i = lim - 1; i >= 0; i--) begin
        if (!mq[i].e && mq[i].o == a) begin
          mq[i].e = 1'b1; mcol = 1;
        end else if (mq[i].e && mq[i].d == a) begin
          mq.delete(i); mtira = 1;
        end
      end
    end
    mrec = (novo_pedido && (oldsz == 4 || origem == destino)) ? 1 : 0;
    if (novo_pedido && mrec == 0)
      mq.push_back('{o: int'(origem), d: int'(destino), e: 1'b0});
    mocup = mq.size();
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("prox_parada", int'(prox_parada), mprox);
    chk("tem_destino", int'(tem_destino), mtem);
    chk("sobe", int'(sobe), msobe);
    chk("coloca_objetos", int'(coloca_objetos), mcol);
    chk("tira_objetos", int'(tira_objetos), mtira);
    chk("recusado", int'(recusado), mrec);
    chk("ocupacao", int'(ocupacao), mocup);
    novo_pedido = 1'b0;
    parada_concluida = 1'b0;
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    novo_pedido = 1'b0;
    parada_concluida = 1'b0;
    #1;
    chk("rst_ocupacao", int'(ocupacao), 0);
    chk("rst_tem_destino", int'(tem_destino), 0);
    chk("rst_prox", int'(prox_parada), 0);
    chk("rst_pulses", int'({coloca_objetos, tira_objetos, recusado}), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic req(input int o, input int d);
    novo_pedido = 1'b1;
    origem = 2'(o);
    destino = 2'(d);
  endtask

  initial begin
    model_reset();
    #2;
    hit_reset();

    // Basic pickup/drop trip 2->3 from floor 0
    andar_atual = 2'd0;
    req(2, 3); cyc();
    cyc();
    chk("trip_tem", int'(tem_destino), 1);
    chk("trip_prox", int'(prox_parada), 2);
    chk("trip_sobe", int'(sobe), 1);
    chk("trip_ocup", int'(ocupacao), 1);
    andar_atual = 2'd2; cyc();
    parada_concluida = 1'b1; cyc();
    chk("trip_coloca", int'(coloca_objetos), 1);
    cyc();
    chk("trip_prox3", int'(prox_parada), 3);
    andar_atual = 2'd3; cyc();
    parada_concluida = 1'b1; cyc();
    chk("trip_tira", int'(tira_objetos), 1);
    chk("trip_ocup0", int'(ocupacao), 0);
    cyc();
    chk("trip_idle", int'(tem_destino), 0);

    // Table full and degenerate request
    hit_reset();
    andar_atual = 2'd0;
    for (int k = 0; k < 4; k++) begin
      req(0, 1); cyc();
    end
    chk("full_4th_ok", int'(recusado), 0);
    req(0, 1); cyc();
    chk("full_rec", int'(recusado), 1);
    chk("full_ocup", int'(ocupacao), 4);
    hit_reset();
    req(2, 2); cyc();
    chk("same_rec", int'(recusado), 1);
    chk("same_ocup", int'(ocupacao), 0);

    // New request coincident with a stop at its own origin
    hit_reset();
    andar_atual = 2'd1;
    req(1, 2); parada_concluida = 1'b1; cyc();
    chk("coinc_col", int'(coloca_objetos), 0);
    cyc();
    chk("coinc_prox", int'(prox_parada), 1);
    chk("coinc_tem", int'(tem_destino), 1);

    // Ride-along versus strict order while sweeping up
    hit_reset();
    andar_atual = 2'd1;
    req(3, 0); cyc();
    cyc();
    chk("sweep_prox3", int'(prox_parada), 3);
    req(2, 3); cyc();
    cyc();
    chk("sweep_next", int'(prox_parada), CARONA ? 2 : 3);
`ifdef SMART_CARGO_CARONA_EN
    andar_atual = 2'd2; cyc();
    parada_concluida = 1'b1; cyc();
    andar_atual = 2'd3; cyc();
    parada_concluida = 1'b1; cyc();
    cyc();
    chk("sweep_rev", int'(prox_parada), 0);
    chk("sweep_rev_sobe", int'(sobe), 0);
`endif

    // Reset while loaded
    hit_reset();
    req(0, 1); cyc();
    req(2, 3); cyc();
    req(1, 3); cyc();
    chk("load_ocup", int'(ocupacao), 3);
    hit_reset();
    cyc();
    chk("post_rst_col", int'(coloca_objetos), 0);
    cyc();

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 299) == 0) hit_reset();
      andar_atual = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        req($urandom_range(0, 3), $urandom_range(0, 3));
      parada_concluida = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
